dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-port arbiter/sequencer in front of the single-port data memory (256 x 32, combinational read, write on posedge clk).
- Port 0 is the core load/store path. Port 1 is a loader/debug master that preloads or inspects memory.
- Grants one access per cycle, round-robin, and drives the memory's address, write data and read/write enables.
- Returns registered read data with a valid pulse, and flags out-of-range addresses.

Parameters:
- ADDR_W, 32, width of requester and memory address buses
- DATA_W, 32, data width
- DEPTH, 256, number of implemented memory words; addresses >= DEPTH are out of range

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- mN_req (N=0,1)  in  1  access request; held until granted
- mN_we  in  1  1=write, 0=read; sampled with req
- mN_addr  in  ADDR_W  word address
- mN_wdata  in  DATA_W  write data
- mN_gnt  out  1  combinational; high in the cycle the request is accepted
- mN_rvalid  out  1  registered; read data valid, one cycle after a read grant
- mN_rdata  out  DATA_W  registered read data
- mN_err  out  1  registered; pulse one cycle after a granted out-of-range access
- mem_addr  out  ADDR_W  to memory read/write address
- mem_wdata  out  DATA_W  to memory write data
- mem_write  out  1  memory write enable
- mem_read  out  1  memory read enable
- mem_rdata  in  DATA_W  combinational read data from memory

Behaviour:
- Reset (rst=0, async):
  - rr_ptr=0 (port 0 favoured), state=IDLE.
  - All mN_rvalid, mN_err = 0; mN_rdata = 0.
  - mem_write, mem_read and mN_gnt forced 0.
- Arbitration (combinational each cycle, outside reset):
  - Single requester: granted.
  - Both requesting: grant port rr_ptr. On any grant, rr_ptr <= ~winner at posedge.
- Granted access drives the memory in the same cycle: mem_addr=addr, mem_wdata=wdata, mem_write=we & in_range, mem_read=~we & in_range.
  - Idle cycles: mem_addr=0, mem_wdata=0, enables=0.
- Write: memory commits at the posedge ending the grant cycle. No rvalid.
- Read: mem_rdata captured at that posedge into mN_rdata, with mN_rvalid=1 for exactly one cycle.
  - mN_rdata holds its value until the next read by that port.
- Out-of-range (addr >= DEPTH): still granted, but no memory enable asserted. mN_err=1 one cycle later; a read also gives rvalid=1 with rdata=0.
- Throughput: one access per cycle, back-to-back permitted. Response latency fixed at 1 cycle.
- Requester rules:
  - A requester may drop req only after gnt.
  - Keeping req high after gnt is a new request.
- FSM (states IDLE, ACTIVE):
  - IDLE->ACTIVE on any grant.
  - ACTIVE->ACTIVE while grants continue; ACTIVE->IDLE on a cycle with no req.
  - State is observable only via rr_ptr update and response pulses.
- Same-address write by one port and read by the other in consecutive cycles: the read returns the new data (write committed first).
- Reset mid-operation: a pending response is dropped (rvalid not asserted) and an in-flight write is suppressed, because mem_write is forced low while rst=0.

Optional Feature:
- Macro DMEM_ARB_LOCK_EN adds input mN_lock.
- With the macro defined: a granted port with lock=1 keeps exclusive ownership. The other port is not granted until the owner presents a grant with lock=0 or drops req; rr_ptr is not updated while locked. Used for read-modify-write sequences.
- Without the macro: no lock ports, pure round-robin.

Decomposition:
- Shared package dmem_pkg holds:
  - DMEM_DEPTH, DMEM_ADDR_W and DMEM_DATA_W constants
  - an enum for the FSM states (IDLE, ACTIVE)
  - a request struct {we, addr, wdata}
- One sub-module, rr_arb2: a 2-way round-robin grant generator with pointer, plus lock qualifier when the macro is defined.
- Response registers and memory muxing stay in dmem_arbiter.

Test Plan:
- Reset, then m0 write addr 1 data 0x4; m0 read addr 1 -> m0_rvalid one cycle after gnt, m0_rdata=0x4, m0_err=0.
- m0 and m1 both request reads (addr 2, addr 4) continuously for 4 cycles -> grants alternate 0,1,0,1; rdata 0x13 and 0x1 respectively.
- m1 write addr 5 = 0xDEAD, m0 read addr 5 in the next cycle -> m0_rdata=0xDEAD.
- m0 read addr 300 -> no mem_read/mem_write, m0_err pulse, m0_rvalid with rdata=0. m1 write addr 256 -> memory unchanged, m1_err pulse.
- Assert rst low in the grant cycle of an m1 write to addr 7 -> addr 7 unchanged, all outputs 0, rr_ptr=0.
- With DMEM_ARB_LOCK_EN: m0 lock=1 for 3 grants while m1 requests -> m1 granted only on the cycle after m0's lock=0 grant.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// DMEM_ARB_LOCK_EN (optional) enables the exclusive-ownership lock inputs.
package dmem_pkg;

   localparam int DMEM_DEPTH  = 256;
   localparam int DMEM_ADDR_W = 32;
   localparam int DMEM_DATA_W = 32;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic                   we;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [DMEM_DATA_W-1:0] wdata;
   } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter, one instance per port.
// DMEM_ARB_LOCK_EN adds the lock input used for read-modify-write sequences.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
`ifdef DMEM_ARB_LOCK_EN
   logic              lock;
`endif
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;
   logic              err;

`ifdef DMEM_ARB_LOCK_EN
   modport master (output req, we, addr, wdata, lock, input gnt, rvalid, rdata, err);
   modport slave  (input req, we, addr, wdata, lock, output gnt, rvalid, rdata, err);
`else
   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
   modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
`endif
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant generator; pointer favours the port that lost last.
// With DMEM_ARB_LOCK_EN a locked owner keeps the grant until it unlocks or drops req.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
`ifdef DMEM_ARB_LOCK_EN
   input  logic [1:0] lock_i,
`endif
   output logic [1:0] gnt_o
);

   logic ptr_q, ptr_d;
   logic winner;
`ifdef DMEM_ARB_LOCK_EN
   logic own_vld_q, own_vld_d;
   logic own_q, own_d;
`endif

   always_comb begin
      gnt_o = 2'b00;
      ptr_d = ptr_q;
`ifdef DMEM_ARB_LOCK_EN
      own_vld_d = 1'b0;
      own_d     = own_q;
`endif
      if (req_i == 2'b11) gnt_o[ptr_q] = 1'b1;
      else                gnt_o = req_i;
`ifdef DMEM_ARB_LOCK_EN
      // An owner that drops req releases the lock in the same cycle.
      if (own_vld_q && req_i[own_q]) begin
         gnt_o        = 2'b00;
         gnt_o[own_q] = 1'b1;
      end
`endif
      if (!rst) gnt_o = 2'b00;
      winner = gnt_o[1];
      if (gnt_o != 2'b00) begin
`ifdef DMEM_ARB_LOCK_EN
         own_vld_d = lock_i[winner];
         own_d     = winner;
         if (!lock_i[winner]) ptr_d = ~winner;
`else
         ptr_d = ~winner;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q     <= 1'b0;
`ifdef DMEM_ARB_LOCK_EN
         own_vld_q <= 1'b0;
         own_q     <= 1'b0;
`endif
      end else begin
         ptr_q     <= ptr_d;
`ifdef DMEM_ARB_LOCK_EN
         own_vld_q <= own_vld_d;
         own_q     <= own_d;
`endif
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port 256x32 data memory; 1-cycle responses.
// DMEM_ARB_LOCK_EN enables per-port lock for exclusive read-modify-write ownership.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int DATA_W = DMEM_DATA_W,
   parameter int DEPTH  = DMEM_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   dmem_arbiter_if.slave     m0,
   dmem_arbiter_if.slave     m1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_rdata
);

   logic [1:0]        req;
   logic [1:0]        gnt;
   logic              any_gnt;
   logic              in_range;
   dmem_req_t         sel;
   arb_state_e        state_q, state_d;
   logic [1:0]        rvalid_q, rvalid_d;
   logic [1:0]        err_q, err_d;
   logic [DATA_W-1:0] rdata_q [2];
   logic [DATA_W-1:0] rdata_d [2];

   assign req = {m1.req, m0.req};

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req_i  (req),
`ifdef DMEM_ARB_LOCK_EN
      .lock_i ({m1.lock, m0.lock}),
`endif
      .gnt_o  (gnt)
   );

   assign any_gnt = |gnt;

   always_comb begin
      if (gnt[1]) sel = '{we: m1.we, addr: m1.addr, wdata: m1.wdata};
      else        sel = '{we: m0.we, addr: m0.addr, wdata: m0.wdata};
   end

   assign in_range  = sel.addr < ADDR_W'(DEPTH);
   assign mem_addr  = any_gnt ? sel.addr  : '0;
   assign mem_wdata = any_gnt ? sel.wdata : '0;
   assign mem_write = any_gnt &  sel.we & in_range;
   assign mem_read  = any_gnt & ~sel.we & in_range;

   // Out-of-range reads still respond, with zero data and an error pulse.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         rvalid_d[i] = gnt[i] & ~sel.we;
         err_d[i]    = gnt[i] & ~in_range;
         rdata_d[i]  = rdata_q[i];
         if (rvalid_d[i]) rdata_d[i] = in_range ? mem_rdata : '0;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_gnt) state_d = ACTIVE;
         ACTIVE:  if (req == 2'b00) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         rvalid_q   <= '0;
         err_q      <= '0;
         rdata_q[0] <= '0;
         rdata_q[1] <= '0;
      end else begin
         state_q    <= state_d;
         rvalid_q   <= rvalid_d;
         err_q      <= err_d;
         rdata_q[0] <= rdata_d[0];
         rdata_q[1] <= rdata_d[1];
      end
   end

   assign m0.gnt    = gnt[0];
   assign m1.gnt    = gnt[1];
   assign m0.rvalid = rvalid_q[0];
   assign m1.rvalid = rvalid_q[1];
   assign m0.err    = err_q[0];
   assign m1.err    = err_q[1];
   assign m0.rdata  = rdata_q[0];
   assign m1.rdata  = rdata_q[1];

endmodule
